// File: rtl/l2_fill_responder_pkg.sv
// Shared types and helpers for the L2 fill responder.
// State encoding, line-offset default and saturating counters.
package l2_fill_responder_pkg;

  localparam int LINE_OFF_DEF = 6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/l2_fill_responder_req_fifo.sv
// Line-address request queue for the L2 fill responder.
// Exposes every entry and a valid mask for parallel merge lookup.
module req_fifo
  import l2_fill_responder_pkg::*;
#(
  parameter int W     = 26,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [W-1:0]              din,
  output logic [W-1:0]              head,
  output logic                      full,
  output logic                      empty,
  output logic [AW:0]               count,
  output logic [DEPTH-1:0][W-1:0]   entries,
  output logic [DEPTH-1:0]          valid
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid   <= '0;
      entries <= '0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= din;
        valid[wr_ptr]   <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l2_fill_responder.sv
// Far end of the icache miss port: queues line fills, merges
// duplicates, and answers each after a fixed memory latency.
module l2_fill_responder
  import l2_fill_responder_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int LINE_OFF = LINE_OFF_DEF,
  parameter int DEPTH    = 4,
  parameter int LATENCY  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  input  logic              fill_ready,
  output logic              busy,
  output logic [15:0]       req_count,
  output logic [15:0]       merge_count
);

  localparam int LW = ADDR_W - LINE_OFF;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_t                    state_q;
  state_t                    state_d;
  logic [CW-1:0]             cnt_q;
  logic [CW-1:0]             cnt_d;
  logic [LW-1:0]             svc_q;
  logic [LW-1:0]             svc_d;
  logic [15:0]               req_cnt_q;
  logic [15:0]               merge_cnt_q;

  logic [LW-1:0]             req_line;
  logic                      accept;
  logic                      merge;
  logic                      push;
  logic                      pop;
  logic [DEPTH-1:0]          hit_vec;

  logic [LW-1:0]             q_head;
  logic                      q_full;
  logic                      q_empty;
  logic [AW:0]               q_count;
  logic [DEPTH-1:0][LW-1:0]  q_entries;
  logic [DEPTH-1:0]          q_valid;
  logic [1:0]                unused_bits;

  assign req_line = req_addr[ADDR_W-1:LINE_OFF];
  assign accept   = req_valid && req_ready;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = q_valid[i] && (q_entries[i] == req_line);
    end
  end

  // A line already issued in RESP must be fetched again.
  assign merge = (|hit_vec)
              || ((state_q == WAIT) && (svc_q == req_line));
  assign push  = accept && !merge;

  req_fifo #(
    .W     (LW),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .din     (req_line),
    .head    (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count),
    .entries (q_entries),
    .valid   (q_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    svc_d   = svc_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          svc_d   = q_head;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (fill_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      svc_q       <= '0;
      req_cnt_q   <= '0;
      merge_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      svc_q   <= svc_d;
      if (accept) begin
        req_cnt_q <= sat_inc16(req_cnt_q);
      end
      if (accept && merge) begin
        merge_cnt_q <= sat_inc16(merge_cnt_q);
      end
    end
  end

  assign req_ready   = !q_full;
  assign fill_valid  = (state_q == RESP);
  assign fill_addr   = fill_valid ? {svc_q, {LINE_OFF{1'b0}}} : '0;
  assign busy        = !q_empty || (state_q != IDLE);
  assign req_count   = req_cnt_q;
  assign merge_count = merge_cnt_q;
  assign unused_bits = {^req_addr[LINE_OFF-1:0], ^q_count};

endmodule
